// File: rtl/exe_dmem_req.sv
// EXE-stage data-memory request issuer: drives the SRAM-like request port and drops responses of flushed requests.
// Optional alignment exception check is compiled in with DMEM_ALE_CHECK_EN.
module exe_dmem_req #(
   parameter int DISCARD_W = 2
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        flush,
   input  logic        exe_valid,
   input  logic        exe_mem_en,
   input  logic        exe_mem_we,
   input  logic [1:0]  exe_mem_size,
   input  logic [31:0] exe_addr,
   input  logic [31:0] exe_wdata,
   input  logic        exe_ex,
   input  logic        mem_ex,
   input  logic        wb_ex,
   input  logic        mem_allowin,
   input  logic        mem_waiting,
   output logic        exe_req_ready_go,
   output logic        exe_wait_data_ok,
   output logic        data_sram_req,
   output logic        data_sram_wr,
   output logic [1:0]  data_sram_size,
   output logic [3:0]  data_sram_wstrb,
   output logic [31:0] data_sram_addr,
   output logic [31:0] data_sram_wdata,
   input  logic        data_sram_addr_ok,
   input  logic        data_sram_data_ok,
   output logic        mem_data_ok,
   output logic        ale
);

   localparam int SW = DISCARD_W + 2;

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_ACCEPTED} state_t;

   state_t               state_reg;
   logic                 cancel_reg;
   logic [DISCARD_W-1:0] discard_cnt_reg;
   logic                 wr_reg;
   logic [1:0]           size_reg;
   logic [3:0]           wstrb_reg;
   logic [31:0]          addr_reg;
   logic [31:0]          wdata_reg;

   logic                 mem_type;
   logic                 issue;
   logic                 in_idle;
   logic                 accept_now;
   logic [3:0]           fmt_wstrb;
   logic [31:0]          fmt_wdata;
   logic                 inc_exe;
   logic                 inc_mem;
   logic                 dec;
   logic [SW-1:0]        cnt_sum;
   logic                 cnt_ovf;

`ifdef DMEM_ALE_CHECK_EN
   assign ale = exe_valid & exe_mem_en & ~exe_ex &
                (((exe_mem_size == 2'd1) & exe_addr[0]) |
                 ((exe_mem_size == 2'd2) & (exe_addr[1:0] != 2'b00)));
`else
   assign ale = 1'b0;
`endif

   assign mem_type   = exe_valid & exe_mem_en & ~exe_ex & ~mem_ex & ~wb_ex & ~ale;
   assign issue      = mem_type & ~flush;
   assign in_idle    = (state_reg == S_IDLE);
   assign accept_now = in_idle & issue & data_sram_addr_ok;

   always_comb begin
      fmt_wdata = exe_wdata;
      fmt_wstrb = 4'b1111;
      case (exe_mem_size)
         2'd0: begin
            fmt_wdata = {4{exe_wdata[7:0]}};
            fmt_wstrb = 4'b0001 << exe_addr[1:0];
         end
         2'd1: begin
            fmt_wdata = {2{exe_wdata[15:0]}};
            fmt_wstrb = 4'b0011 << {exe_addr[1], 1'b0};
         end
         default: begin
            fmt_wdata = exe_wdata;
            fmt_wstrb = 4'b1111;
         end
      endcase
      if (!exe_mem_we) fmt_wstrb = 4'b0000;
   end

   // Fresh requests come straight from EXE; a stalled one replays the latched copy
   assign data_sram_req   = in_idle ? issue : (state_reg == S_REQ);
   assign data_sram_wr    = in_idle ? exe_mem_we   : wr_reg;
   assign data_sram_size  = in_idle ? exe_mem_size : size_reg;
   assign data_sram_wstrb = in_idle ? fmt_wstrb    : wstrb_reg;
   assign data_sram_addr  = in_idle ? exe_addr     : addr_reg;
   assign data_sram_wdata = in_idle ? fmt_wdata    : wdata_reg;

   assign exe_req_ready_go = ~mem_type | (state_reg == S_ACCEPTED) | accept_now;
   assign exe_wait_data_ok = (state_reg == S_ACCEPTED) | accept_now;

   assign mem_data_ok = data_sram_data_ok & (discard_cnt_reg == '0);

   assign inc_exe = ((state_reg == S_REQ) & data_sram_addr_ok & (cancel_reg | flush)) |
                    ((state_reg == S_ACCEPTED) & flush);
   assign inc_mem = flush & mem_waiting & ~data_sram_data_ok;
   assign dec     = data_sram_data_ok & (discard_cnt_reg != '0);
   assign cnt_sum = SW'(discard_cnt_reg) + SW'(inc_exe) + SW'(inc_mem) - SW'(dec);
   assign cnt_ovf = cnt_sum > SW'((1 << DISCARD_W) - 1);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_reg       <= S_IDLE;
         cancel_reg      <= 1'b0;
         discard_cnt_reg <= '0;
         wr_reg          <= 1'b0;
         size_reg        <= 2'd0;
         wstrb_reg       <= 4'd0;
         addr_reg        <= 32'd0;
         wdata_reg       <= 32'd0;
      end else begin
         discard_cnt_reg <= cnt_sum[DISCARD_W-1:0];
         case (state_reg)
            S_IDLE: begin
               if (issue) begin
                  if (data_sram_addr_ok) begin
                     state_reg <= S_ACCEPTED;
                  end else begin
                     state_reg <= S_REQ;
                     wr_reg    <= exe_mem_we;
                     size_reg  <= exe_mem_size;
                     wstrb_reg <= fmt_wstrb;
                     addr_reg  <= exe_addr;
                     wdata_reg <= fmt_wdata;
                  end
               end
            end
            S_REQ: begin
               // The bus handshake must complete even when the instruction is dead
               if (data_sram_addr_ok) begin
                  if (cancel_reg | flush) begin
                     state_reg  <= S_IDLE;
                     cancel_reg <= 1'b0;
                  end else begin
                     state_reg <= S_ACCEPTED;
                  end
               end else if (flush) begin
                  cancel_reg <= 1'b1;
               end
            end
            S_ACCEPTED: begin
               if (flush | mem_allowin) state_reg <= S_IDLE;
            end
            default: state_reg <= S_IDLE;
         endcase
      end
   end

   assert property (@(posedge clk) disable iff (!resetn) !cnt_ovf);

endmodule

// File: tb/tb_exe_dmem_req.sv
// Randomized self-checking bench for exe_dmem_req against a transaction-level reference model.
module tb_exe_dmem_req;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        flush = 0, exe_valid = 0, exe_mem_en = 0, exe_mem_we = 0;
   logic [1:0]  exe_mem_size = 0;
   logic [31:0] exe_addr = 0, exe_wdata = 0;
   logic        exe_ex = 0, mem_ex = 0, wb_ex = 0, mem_allowin = 0, mem_waiting = 0;
   logic        data_sram_addr_ok = 0, data_sram_data_ok = 0;
   logic        exe_req_ready_go, exe_wait_data_ok, data_sram_req, data_sram_wr;
   logic [1:0]  data_sram_size;
   logic [3:0]  data_sram_wstrb;
   logic [31:0] data_sram_addr, data_sram_wdata;
   logic        mem_data_ok, ale;

   int n_total = 0;
   int n_bad   = 0;

   // Reference model: one request that may be waiting on the bus, a flag that
   // an accepted request is still parked in EXE, and the number of owed discards.
   bit          held, held_dead, granted, need_new;
   int          owed;
   logic        h_wr;
   logic [1:0]  h_size;
   logic [3:0]  h_wstrb;
   logic [31:0] h_addr, h_wdata;

   exe_dmem_req #(.DISCARD_W(2)) dut (
      .clk(clk), .resetn(resetn), .flush(flush),
      .exe_valid(exe_valid), .exe_mem_en(exe_mem_en), .exe_mem_we(exe_mem_we),
      .exe_mem_size(exe_mem_size), .exe_addr(exe_addr), .exe_wdata(exe_wdata),
      .exe_ex(exe_ex), .mem_ex(mem_ex), .wb_ex(wb_ex),
      .mem_allowin(mem_allowin), .mem_waiting(mem_waiting),
      .exe_req_ready_go(exe_req_ready_go), .exe_wait_data_ok(exe_wait_data_ok),
      .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
      .data_sram_size(data_sram_size), .data_sram_wstrb(data_sram_wstrb),
      .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
      .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok),
      .mem_data_ok(mem_data_ok), .ale(ale)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] ref_wdata(input logic [1:0] sz, input logic [31:0] d);
      if (sz == 2'd0) return {24'd0, d[7:0]} * 32'h0101_0101;
      if (sz == 2'd1) return {16'd0, d[15:0]} * 32'h0001_0001;
      return d;
   endfunction

   function automatic logic [3:0] ref_wstrb(input logic we, input logic [1:0] sz, input logic [31:0] a);
      int lane;
      if (!we) return 4'd0;
      lane = int'(a[1:0]);
      if (sz == 2'd0) return 4'(1 << lane);
      if (sz == 2'd1) return 4'(3 << (lane & 2));
      return 4'hf;
   endfunction

   function automatic bit ref_ale();
`ifdef DMEM_ALE_CHECK_EN
      if (!(exe_valid && exe_mem_en && !exe_ex)) return 0;
      if (exe_mem_size == 2'd1) return exe_addr % 2 != 0;
      if (exe_mem_size == 2'd2) return exe_addr % 4 != 0;
      return 0;
`else
      return 0;
`endif
   endfunction

   task automatic model_reset();
      held = 0; held_dead = 0; granted = 0; owed = 0; need_new = 1;
   endtask

   // Inputs are set before calling; checks happen between clock edges
   task automatic step();
      bit a, mt, iss, acc, e_req, e_rg, e_wait, e_mdok, from_exe, dc;
      int inc;
      #1;
      a      = ref_ale();
      mt     = exe_valid && exe_mem_en && !exe_ex && !mem_ex && !wb_ex && !a;
      iss    = mt && !flush;
      from_exe = !held && !granted;
      acc    = from_exe && iss && data_sram_addr_ok;
      e_req  = held || (from_exe && iss);
      e_rg   = !mt || granted || acc;
      e_wait = granted || acc;
      e_mdok = data_sram_data_ok && owed == 0;
      check_val("req", data_sram_req, e_req);
      if (e_req) begin
         check_val("addr",  data_sram_addr,  held ? h_addr  : exe_addr);
         check_val("size",  data_sram_size,  held ? h_size  : exe_mem_size);
         check_val("wr",    data_sram_wr,    held ? h_wr    : exe_mem_we);
         check_val("wstrb", data_sram_wstrb, held ? h_wstrb : ref_wstrb(exe_mem_we, exe_mem_size, exe_addr));
         check_val("wdata", data_sram_wdata, held ? h_wdata : ref_wdata(exe_mem_size, exe_wdata));
      end
      check_val("ready_go", exe_req_ready_go, e_rg);
      check_val("wait_data_ok", exe_wait_data_ok, e_wait);
      check_val("mem_data_ok", mem_data_ok, e_mdok);
      check_val("ale", ale, a);
      if (e_req && data_sram_addr_ok)
         $display("txn t=%0t wr=%0b size=%0d addr=%h wstrb=%b wdata=%h", $time,
                  data_sram_wr, data_sram_size, data_sram_addr, data_sram_wstrb, data_sram_wdata);

      inc = 0;
      if (held) begin
         if (data_sram_addr_ok) begin
            held = 0;
            if (held_dead || flush) inc++;
            else granted = 1;
         end else if (flush) held_dead = 1;
      end else if (granted) begin
         if (flush) begin inc++; granted = 0; end
         else if (mem_allowin) granted = 0;
      end else if (iss) begin
         if (data_sram_addr_ok) granted = 1;
         else begin
            held = 1; held_dead = 0;
            h_wr = exe_mem_we; h_size = exe_mem_size; h_addr = exe_addr;
            h_wstrb = ref_wstrb(exe_mem_we, exe_mem_size, exe_addr);
            h_wdata = ref_wdata(exe_mem_size, exe_wdata);
         end
      end
      if (flush && mem_waiting && !data_sram_data_ok) inc++;
      dc = data_sram_data_ok && owed > 0;
      owed = owed + inc - int'(dc);
      need_new = (e_rg && mem_allowin) || flush || !exe_valid;
   endtask

   task automatic set_instr(input logic v, input logic we, input logic [1:0] sz,
                            input logic [31:0] a, input logic [31:0] d);
      exe_valid = v; exe_mem_en = 1; exe_mem_we = we; exe_mem_size = sz;
      exe_addr = a; exe_wdata = d; exe_ex = 0;
   endtask

   initial begin
      int committed, add;
      model_reset();
      #2;
      check_val("rst_req", data_sram_req, 0);
      check_val("rst_mem_data_ok", mem_data_ok, 0);
      check_val("rst_ready_go", exe_req_ready_go, 1);
      check_val("rst_wait", exe_wait_data_ok, 0);
      @(negedge clk);
      resetn = 1;

      // Store byte, accepted immediately, then handed to MEM
      set_instr(1, 1, 2'd0, 32'h1002, 32'h0000_00ab);
      data_sram_addr_ok = 1; mem_allowin = 0;
      step();
      check_val("sb_wstrb_const", data_sram_wstrb, 4'b0100);
      check_val("sb_wdata_const", data_sram_wdata, 32'habab_abab);
      @(negedge clk);
      data_sram_addr_ok = 0; mem_allowin = 1;
      step();
      @(negedge clk);
      exe_valid = 0;
      step();

      // Randomized traffic
      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(negedge clk);
         if (need_new) begin
            exe_valid    = $urandom_range(0, 9) != 0;
            exe_mem_en   = $urandom_range(0, 9) < 7;
            exe_mem_we   = $urandom_range(0, 1) == 1;
            exe_mem_size = 2'($urandom_range(0, 2));
            exe_addr     = $urandom;
            exe_wdata    = $urandom;
            exe_ex       = $urandom_range(0, 19) == 0;
         end
         mem_ex            = $urandom_range(0, 19) == 0;
         wb_ex             = $urandom_range(0, 19) == 0;
         data_sram_addr_ok = $urandom_range(0, 1) == 1;
         data_sram_data_ok = $urandom_range(0, 9) < 3;
         mem_waiting       = $urandom_range(0, 9) < 4;
         mem_allowin       = $urandom_range(0, 9) < 7;
         flush             = $urandom_range(0, 19) == 0;
         if (flush) begin
            // Keep the discard debt within what a 2-bit counter can hold
            committed = owed + int'(held && held_dead);
            add = int'(held && !held_dead) + int'(granted) + int'(mem_waiting && !data_sram_data_ok);
            if (committed - int'(data_sram_data_ok && owed > 0) + add > 3) flush = 0;
         end
         step();
      end

      // Drain everything, then build a dead request and a live one in flight
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         exe_valid = 0; flush = 0; mem_ex = 0; wb_ex = 0; mem_waiting = 0;
         data_sram_data_ok = 1; data_sram_addr_ok = 1; mem_allowin = 1;
         step();
      end
      @(negedge clk);
      set_instr(1, 0, 2'd2, 32'h2000, 32'h0);
      data_sram_addr_ok = 0; data_sram_data_ok = 0; mem_allowin = 0;
      step();
      @(negedge clk);
      flush = 1;
      step();
      @(negedge clk);
      flush = 0; data_sram_addr_ok = 1;
      step();
      check_val("owed_after_cancel", owed, 1);
      @(negedge clk);
      set_instr(1, 0, 2'd2, 32'h3000, 32'h0);
      data_sram_addr_ok = 0;
      step();
      @(negedge clk);
      resetn = 0; data_sram_data_ok = 1; exe_valid = 0;
      #1;
      check_val("async_rst_req", data_sram_req, 0);
      check_val("async_rst_cnt", mem_data_ok, 1);
      check_val("async_rst_wait", exe_wait_data_ok, 0);
      model_reset();
      @(negedge clk);
      resetn = 1; data_sram_data_ok = 1;
      step();

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
